// File: rtl/snd_pkg.sv
// Shared types and constants for the expansion-audio mixer.
package snd_pkg;

  // Mixer sequencer states.
  typedef enum logic [1:0] {
    SND_IDLE = 2'd0,
    SND_MAC  = 2'd1,
    SND_SAT  = 2'd2,
    SND_FILT = 2'd3
  } snd_state_e;

  localparam int SND_OUT_W  = 16;
  localparam int SND_GAIN_W = 8;

  // Accumulator width: one full product plus enough headroom for CH_NUM
  // products and a spare bit, so the running sum can never wrap.
  function automatic int snd_acc_w(input int ch_w, input int ch_num);
    return ch_w + SND_GAIN_W + $clog2(ch_num) + 1;
  endfunction

endpackage

// File: rtl/snd_lpf.sv
// One-pole low-pass filter: y += (x - y) >>> FILT_SHIFT, clamped to 16 bits.
// FILT_SHIFT == 0 makes the filter a plain enabled register.
module snd_lpf #(
  parameter int FILT_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] x,
  output logic [15:0] y
);

  logic [15:0]        y_q, y_d;
  logic signed [16:0] diff;
  logic signed [16:0] step;
  logic signed [17:0] sum;

  // Next filter state; only moves when en is high, otherwise holds.
  always_comb begin
    y_d  = y_q;
    diff = $signed({1'b0, x}) - $signed({1'b0, y_q});
    step = diff >>> FILT_SHIFT;
    sum  = $signed({2'b00, y_q}) + $signed({step[16], step});
    if (en) begin
      if (FILT_SHIFT == 0) begin
        y_d = x;
      end else if (sum < 18'sd0) begin
        y_d = 16'h0000;
      end else if (sum > 18'sd65535) begin
        y_d = 16'hFFFF;
      end else begin
        y_d = sum[15:0];
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= 16'h0000;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/snd_mixer.sv
// Expansion-audio mixer: one sample per falling edge of M2, channels summed
// serially through a shared multiply-accumulate, then shifted, saturated and
// low-pass filtered into a 16-bit level for the DAC.
// snd_stb is a single-clk strobe, high in the same cycle snd_out first shows
// the new sample; there is no back-pressure, the consumer must take it then.
module snd_mixer
  import snd_pkg::*;
#(
  parameter int CH_NUM     = 4,
  parameter int CH_W       = 16,
  parameter int GAIN_SHIFT = 6,
  parameter int FILT_SHIFT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m2,
  input  logic [CH_NUM*CH_W-1:0]       ch_in,
  input  logic [CH_NUM*SND_GAIN_W-1:0] ch_gain,
  input  logic [CH_NUM-1:0]            ch_en,
  output logic [SND_OUT_W-1:0]         snd_out,
  output logic                         snd_stb,
  output logic                         ovr,
  input  logic                         ovr_clr
);

  localparam int ACC_W  = snd_acc_w(CH_W, CH_NUM);
  localparam int PROD_W = CH_W + SND_GAIN_W;
  localparam int IDX_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH_NUM - 1);

  snd_state_e state_q, state_d;

  logic m2_s1_q, m2_s1_d;
  logic m2_s2_q, m2_s2_d;
  logic m2_prev_q, m2_prev_d;
  logic tick;

  logic [CH_NUM*CH_W-1:0]       ch_snap_q, ch_snap_d;
  logic [CH_NUM*SND_GAIN_W-1:0] gain_snap_q, gain_snap_d;
  logic [CH_NUM-1:0]            en_snap_q, en_snap_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [ACC_W-1:0]             acc_q, acc_d;
  logic                         ovr_q, ovr_d;
  logic                         stb_q, stb_d;

  logic [CH_W-1:0]       ch_sel;
  logic [SND_GAIN_W-1:0] gain_sel;
  logic                  en_sel;
  logic [PROD_W-1:0]     prod;
  logic [ACC_W-1:0]      acc_shr;
  logic [SND_OUT_W-1:0]  sat_x;
  logic                  lpf_en;

  // M2 synchroniser and falling-edge detect; tick lasts one clk.
  always_comb begin
    m2_s1_d   = m2;
    m2_s2_d   = m2_s1_q;
    m2_prev_d = m2_s2_q;
    tick      = m2_prev_q & ~m2_s2_q;
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SND_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencer next state: IDLE -> MAC (CH_NUM clks) -> SAT -> FILT -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SND_IDLE: if (tick) state_d = SND_MAC;
      SND_MAC:  if (idx_q == LAST_IDX) state_d = SND_SAT;
      SND_SAT:  state_d = SND_FILT;
      SND_FILT: state_d = SND_IDLE;
      default:  state_d = SND_IDLE;
    endcase
  end

  // Select the snapshot channel addressed by idx and form its product.
  always_comb begin
    ch_sel   = '0;
    gain_sel = '0;
    en_sel   = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (idx_q == IDX_W'(i)) begin
        ch_sel   = ch_snap_q[i*CH_W +: CH_W];
        gain_sel = gain_snap_q[i*SND_GAIN_W +: SND_GAIN_W];
        en_sel   = en_snap_q[i];
      end
    end
    prod = en_sel ? (PROD_W'(ch_sel) * PROD_W'(gain_sel)) : '0;
  end

  // Gain shift and saturation of the finished sum into the filter input.
  always_comb begin
    acc_shr = acc_q >> GAIN_SHIFT;
    sat_x   = (|acc_shr[ACC_W-1:SND_OUT_W]) ? {SND_OUT_W{1'b1}}
                                            : acc_shr[SND_OUT_W-1:0];
    lpf_en  = (state_q == SND_SAT);
  end

  // Datapath and output next values: snapshot, accumulate, strobe, overrun.
  always_comb begin
    ch_snap_d   = ch_snap_q;
    gain_snap_d = gain_snap_q;
    en_snap_d   = en_snap_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    stb_d       = (state_q == SND_SAT);
    ovr_d       = ovr_q;
    case (state_q)
      SND_IDLE: begin
        if (tick) begin
          ch_snap_d   = ch_in;
          gain_snap_d = ch_gain;
          en_snap_d   = ch_en;
          idx_d       = '0;
          acc_d       = '0;
        end
      end
      SND_MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        if (idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(1);
      end
      default: ;
    endcase
    // A new overrun outranks a clear arriving in the same clk.
    if (tick && (state_q != SND_IDLE)) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  // Datapath, synchroniser and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m2_s1_q     <= 1'b0;
      m2_s2_q     <= 1'b0;
      m2_prev_q   <= 1'b0;
      ch_snap_q   <= '0;
      gain_snap_q <= '0;
      en_snap_q   <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      ovr_q       <= 1'b0;
      stb_q       <= 1'b0;
    end else begin
      m2_s1_q     <= m2_s1_d;
      m2_s2_q     <= m2_s2_d;
      m2_prev_q   <= m2_prev_d;
      ch_snap_q   <= ch_snap_d;
      gain_snap_q <= gain_snap_d;
      en_snap_q   <= en_snap_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      ovr_q       <= ovr_d;
      stb_q       <= stb_d;
    end
  end

  // The filter register doubles as the snd_out holding register.
  snd_lpf #(
    .FILT_SHIFT(FILT_SHIFT)
  ) u_lpf (
    .clk(clk),
    .rst(rst),
    .en (lpf_en),
    .x  (sat_x),
    .y  (snd_out)
  );

  assign snd_stb = stb_q;
  assign ovr     = ovr_q;

endmodule

// File: tb/tb_snd_mixer.sv
// Directed bench for snd_mixer: dut0 runs with the filter bypassed, dut2 with
// FILT_SHIFT=2; both share every input.
module tb_snd_mixer;

  logic        clk;
  logic        rst;
  logic        m2;
  logic [63:0] ch_in;
  logic [31:0] ch_gain;
  logic [3:0]  ch_en;
  logic        ovr_clr;
  logic [15:0] snd_out0, snd_out2;
  logic        snd_stb0, snd_stb2;
  logic        ovr0, ovr2;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int nstb;
  bit ok;
  logic [15:0] decay_exp [4];

  snd_mixer #(.CH_NUM(4), .CH_W(16), .GAIN_SHIFT(6), .FILT_SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .m2(m2), .ch_in(ch_in), .ch_gain(ch_gain),
    .ch_en(ch_en), .snd_out(snd_out0), .snd_stb(snd_stb0), .ovr(ovr0),
    .ovr_clr(ovr_clr)
  );

  snd_mixer #(.CH_NUM(4), .CH_W(16), .GAIN_SHIFT(6), .FILT_SHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .m2(m2), .ch_in(ch_in), .ch_gain(ch_gain),
    .ch_en(ch_en), .snd_out(snd_out2), .snd_stb(snd_stb2), .ovr(ovr2),
    .ovr_clr(ovr_clr)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input logic [15:0] c0, input logic [15:0] c1,
                        input logic [15:0] c2, input logic [15:0] c3,
                        input logic [7:0] g, input logic [3:0] en);
    ch_in   = {c3, c2, c1, c0};
    ch_gain = {g, g, g, g};
    ch_en   = en;
  endtask

  // Produce one M2 falling edge.
  task automatic pulse_m2();
    m2 = 1'b1;
    repeat (3) @(posedge clk);
    #2 m2 = 1'b0;
  endtask

  // Wait (bounded) until the internal tick is seen, sampled #1 after posedge.
  task automatic wait_tick(output bit seen);
    int n;
    n = 0;
    while (!dut0.tick && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    seen = dut0.tick;
    if (!seen) check("tick_seen", 32'd0, 32'd1);
  endtask

  // One sample: latency in clks from tick to snd_stb (-1 if no tick).
  // With scramble set, inputs are trashed right after the snapshot edge.
  task automatic run_sample(input bit scramble, output int l);
    bit seen;
    pulse_m2();
    wait_tick(seen);
    l = -1;
    if (seen) begin
      l = 0;
      while (!snd_stb0 && l < 20) begin
        @(posedge clk); #1;
        l++;
        if (scramble && l == 1) begin
          ch_in   = {$urandom, $urandom};
          ch_gain = $urandom;
          ch_en   = 4'hF;
        end
      end
      check("stb2_with_stb0", {31'd0, snd_stb2}, 32'd1);
    end
    @(posedge clk); #1;
  endtask

  // Sample with a second M2 edge landing mid-computation; optionally pulse
  // ovr_clr in exactly the clk of the dropped tick. Returns strobe count.
  task automatic run_ovr(input bit clr_same, output int cnt);
    bit seen;
    cnt = 0;
    pulse_m2();
    wait_tick(seen);
    m2 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 m2 = 1'b0;
    if (clr_same) begin
      @(posedge clk); #1;
      wait_tick(seen);
      ovr_clr = 1'b1;
      @(posedge clk); #1;
      ovr_clr = 1'b0;
      check("ovr_set_beats_clr", {31'd0, ovr0}, 32'd1);
    end
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (snd_stb0) cnt++;
    end
  endtask

  initial begin
    decay_exp[0] = 16'h3780;
    decay_exp[1] = 16'h29A0;
    decay_exp[2] = 16'h1F38;
    decay_exp[3] = 16'h176A;
    rst     = 1'b1;
    m2      = 1'b0;
    ovr_clr = 1'b0;
    set_ch(16'h0, 16'h0, 16'h0, 16'h0, 8'd0, 4'b0000);
    repeat (3) @(posedge clk); #1;
    check("reset_snd_out", {16'd0, snd_out0}, 32'd0);
    check("reset_snd_stb", {31'd0, snd_stb0}, 32'd0);
    check("reset_ovr", {31'd0, ovr0}, 32'd0);
    check("reset_snd_out_f", {16'd0, snd_out2}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Filter step 0 -> 0x8000, then back to 0.
    set_ch(16'h8000, 16'h0, 16'h0, 16'h0, 8'd64, 4'b0001);
    run_sample(1'b0, lat);
    check("step_latency", lat, 32'd6);
    check("step_bypass", {16'd0, snd_out0}, 32'h8000);
    check("step_y1", {16'd0, snd_out2}, 32'h2000);
    run_sample(1'b0, lat);
    check("step_y2", {16'd0, snd_out2}, 32'h3800);
    run_sample(1'b0, lat);
    check("step_y3", {16'd0, snd_out2}, 32'h4A00);
    set_ch(16'h0, 16'h0, 16'h0, 16'h0, 8'd64, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      run_sample(1'b0, lat);
      check($sformatf("decay_y%0d", k), {16'd0, snd_out2}, {16'd0, decay_exp[k]});
    end
    check("decay_bypass", {16'd0, snd_out0}, 32'h0);

    // Unity gain, single channel.
    set_ch(16'h1000, 16'h0, 16'h0, 16'h0, 8'd64, 4'b0001);
    run_sample(1'b0, lat);
    check("unity_latency", lat, 32'd6);
    check("unity_out", {16'd0, snd_out0}, 32'h1000);

    // Saturation: every channel full scale at max gain.
    set_ch(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'd255, 4'b1111);
    run_sample(1'b0, lat);
    check("sat_out", {16'd0, snd_out0}, 32'hFFFF);

    // Enable mask and mix; inputs trashed after the snapshot.
    set_ch(16'd100, 16'd200, 16'd300, 16'd400, 8'd64, 4'b1010);
    run_sample(1'b1, lat);
    check("mix_latency", lat, 32'd6);
    check("mix_out", {16'd0, snd_out0}, 32'd600);

    // M2 stopped: no strobes, output holds.
    nstb = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (snd_stb0) nstb++;
    end
    check("idle_no_stb", nstb, 32'd0);
    check("idle_hold", {16'd0, snd_out0}, 32'd600);

    // Overrun: second edge during MAC is dropped and flagged.
    set_ch(16'h1234, 16'h0, 16'h0, 16'h0, 8'd64, 4'b0001);
    run_ovr(1'b0, nstb);
    check("ovr_one_stb", nstb, 32'd1);
    check("ovr_sample", {16'd0, snd_out0}, 32'h1234);
    check("ovr_set", {31'd0, ovr0}, 32'd1);
    repeat (10) @(posedge clk); #1;
    check("ovr_sticky", {31'd0, ovr0}, 32'd1);
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    check("ovr_cleared", {31'd0, ovr0}, 32'd0);

    // Clear and new overrun in the same clk.
    set_ch(16'h1234, 16'h0100, 16'h0, 16'h0, 8'd128, 4'b0011);
    run_ovr(1'b1, nstb);
    check("ovr2_one_stb", nstb, 32'd1);
    check("ovr2_sample", {16'd0, snd_out0}, 32'h2668);
    check("ovr2_still_set", {31'd0, ovr0}, 32'd1);

    // Async reset during MAC idx=2.
    set_ch(16'h8000, 16'h0, 16'h0, 16'h0, 8'd64, 4'b0001);
    pulse_m2();
    wait_tick(ok);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_snd_out", {16'd0, snd_out0}, 32'd0);
    check("rst_mid_snd_stb", {31'd0, snd_stb0}, 32'd0);
    check("rst_mid_ovr", {31'd0, ovr0}, 32'd0);
    check("rst_mid_snd_out_f", {16'd0, snd_out2}, 32'd0);
    check("rst_mid_ovr_f", {31'd0, ovr2}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    run_sample(1'b0, lat);
    check("post_rst_latency", lat, 32'd6);
    check("post_rst_bypass", {16'd0, snd_out0}, 32'h8000);
    check("post_rst_filter", {16'd0, snd_out2}, 32'h2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snd_mixer.md
Name: snd_mixer

Overview:
- Mixes the mapper expansion-audio channels into the single 16-bit unsigned level consumed by the delta-sigma audio DAC.
- Sampling is tied to the CPU M2 clock: one new mixed sample per falling edge of M2.
- The channels are summed serially through one shared multiply-accumulate unit, then scaled, saturated and low-pass filtered.
- Sits between the mapper sound outputs and the DAC volume input.

Parameters:
- CH_NUM, 4, number of input channels (1..8).
- CH_W, 16, width of each unsigned channel sample.
- GAIN_SHIFT, 6, right shift applied to the accumulated sum; gain value 64 means unity.
- FILT_SHIFT, 2, one-pole low-pass coefficient 2^-FILT_SHIFT; 0 bypasses the filter.

Ports:
- clk, in, 1, system clock (same domain as the mapper clock).
- rst, in, 1, asynchronous active-high reset.
- m2, in, 1, raw CPU M2; asynchronous to clk.
- ch_in, in, CH_NUM*CH_W, packed channel samples, channel 0 in the LSBs.
- ch_gain, in, CH_NUM*8, packed per-channel unsigned gains.
- ch_en, in, CH_NUM, per-channel enable; a disabled channel contributes 0.
- snd_out, out, 16, filtered mix to the DAC.
- snd_stb, out, 1, one-clk pulse when snd_out updates.
- ovr, out, 1, sticky flag: a sample tick arrived while the mixer was busy.
- ovr_clr, in, 1, clears ovr.

Behaviour:
- Reset is asynchronous: rst high forces state IDLE; snd_out, snd_stb, ovr, accumulator, filter state and the m2 synchroniser all go to 0.
- m2 passes through a 2-flop synchroniser plus one edge register.
  - tick = 1 on the clk after a synchronised 1→0 transition.
- State machine IDLE → MAC → SAT → FILT → IDLE.
- IDLE:
  - On tick: snapshot ch_in, ch_gain and ch_en into internal registers, clear acc, set idx=0, go to MAC.
  - Inputs may change freely after the snapshot.
- MAC, one channel per clk:
  - acc += ch_en[idx] ? ch[idx]*gain[idx] : 0.
  - Product width is CH_W+8; acc width is CH_W+8+clog2(CH_NUM)+1, so it cannot wrap.
  - When idx==CH_NUM-1, go to SAT. MAC lasts exactly CH_NUM cycles.
- SAT:
  - x = acc >> GAIN_SHIFT (logical shift).
  - If any bit above bit 15 is set, x = 16'hFFFF; otherwise x = low 16 bits.
  - Go to FILT.
- FILT:
  - If FILT_SHIFT == 0: y = x.
  - Otherwise: y = y + ((x - y) >>> FILT_SHIFT), with a 17-bit signed difference and arithmetic shift; the result is clamped to 0..16'hFFFF.
  - Register snd_out = y, pulse snd_stb for 1 clk, go to IDLE.
- Latency: tick → snd_stb is CH_NUM+2 clks, i.e. 6 with defaults.
- Overrun: a tick in any state other than IDLE is dropped, the sample in progress completes unaffected, and ovr is set.
- ovr_clr and a simultaneous new overrun in the same clk: the set wins.
- snd_out holds its value between strobes; it is never glitched mid-computation.
- rst asserted mid-MAC aborts immediately: no strobe, all outputs are 0 on the next edge.
- m2 stopped (console in reset): no ticks; snd_out holds its last value.

Decomposition:
- Shared package snd_pkg holds:
  - the state enum typedef (SND_IDLE, SND_MAC, SND_SAT, SND_FILT);
  - the constants SND_OUT_W=16 and SND_GAIN_W=8;
  - a function returning the accumulator width from CH_W and CH_NUM.
- One sub-module, snd_lpf: the one-pole filter with FILT_SHIFT parameter, inputs clk/rst/en/x[15:0], output y[15:0] and its state register.
- The MAC sequencer and synchroniser stay in snd_mixer.

Test Plan:
- Unity gain, single channel:
  - Setup: ch0=16'h1000, gain0=64, ch_en=4'b0001, FILT_SHIFT=0.
  - One m2 falling edge → snd_stb exactly 6 clks after tick; snd_out=16'h1000.
- Saturation:
  - Setup: all four channels 16'hFFFF, gains 255, all enabled.
  - → snd_out=16'hFFFF; no wrap to a small value.
- Enable and mix:
  - Setup: ch0..3 = 100, 200, 300, 400, gains 64, ch_en=4'b1010.
  - → snd_out=600.
- Filter step:
  - Setup: FILT_SHIFT=2, step input x=16'h8000 from y=0.
  - → successive snd_out = 16'h2000, 16'h3800, 16'h4A00.
  - Step back to x=0 → output decreases monotonically.
- Overrun:
  - Stimulus: second m2 falling edge 3 clks after the first tick.
  - → exactly one snd_stb; ovr=1 and held until ovr_clr.
  - ovr_clr and a new overrun in the same clk → ovr stays 1.
- Async reset mid-MAC:
  - Stimulus: assert rst during MAC idx=2, between clk edges.
  - → snd_out, snd_stb, ovr are 0 immediately.
  - After release, the next tick yields a correct sample with the filter restarted from 0.
